// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the sequential multiplier
package mul_pkg;

   localparam int WIDTH_DEF = 32;

   // Counter width for a given operand width, never narrower than one bit
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_w(WIDTH_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - request/result bundle between the ALU controller and the multiplier
interface mul_seq_if
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             sign;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             Z;
   logic             N;
   logic             C;
   logic             V;

   modport master (
      output start, A, B, sign,
      input  busy, done, hi, lo, Z, N, C, V
   );

   modport slave (
      input  start, A, B, sign,
      output busy, done, hi, lo, Z, N, C, V
   );
endinterface

// File: rtl/mag_abs.sv
// rtl/mag_abs.sv - conditional two's-complement magnitude of one operand
module mag_abs #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in_val,
   input  logic             sign,
   output logic [WIDTH-1:0] mag,
   output logic             in_neg
);

   // Negate only signed negative inputs; the most-negative value maps to 2^(WIDTH-1) as unsigned
   always_comb begin
      in_neg = sign & in_val[WIDTH-1];
      mag    = in_neg ? (~in_val + WIDTH'(1)) : in_val;
   end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - shift-add multiplier with start/busy/done handshake and ALU flags
module mul_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   mul_seq_if.slave    bus
);

   localparam int CW = cnt_w(WIDTH);
   localparam int PW = 2 * WIDTH;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic              neg_q, neg_d;
   logic              sign_q, sign_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic              z_q, z_d;
   logic              n_q, n_d;
   logic              c_q, c_d;
   logic              v_q, v_d;

   logic [WIDTH-1:0]  a_mag, b_mag;
   logic              a_neg, b_neg;
   logic [PW-1:0]     prod;
   logic [WIDTH-1:0]  prod_hi, prod_lo;

   mag_abs #(.WIDTH(WIDTH)) u_abs_a (
      .in_val (bus.A),
      .sign   (bus.sign),
      .mag    (a_mag),
      .in_neg (a_neg)
   );

   mag_abs #(.WIDTH(WIDTH)) u_abs_b (
      .in_val (bus.B),
      .sign   (bus.sign),
      .mag    (b_mag),
      .in_neg (b_neg)
   );

   // Signed fix-up of the magnitude product: one full-width negation
   always_comb begin
      prod    = neg_q ? (~acc_q + PW'(1)) : acc_q;
      prod_hi = prod[PW-1:WIDTH];
      prod_lo = prod[WIDTH-1:0];
   end

   // Next-state, datapath step and result capture
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      sign_d   = sign_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      z_d      = z_q;
      n_d      = n_q;
      c_d      = c_q;
      v_d      = v_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               neg_d    = a_neg ^ b_neg;
               sign_d   = bus.sign;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            hi_d    = prod_hi;
            lo_d    = prod_lo;
            z_d     = (prod == '0);
            n_d     = sign_q & prod[PW-1];
            v_d     = sign_q ? (prod_hi != {WIDTH{prod_lo[WIDTH-1]}}) : (prod_hi != '0);
            c_d     = ~sign_q & (prod_hi != '0);
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         sign_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         sign_q   <= sign_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         z_q      <= z_d;
         n_q      <= n_d;
         c_q      <= c_d;
         v_q      <= v_d;
      end
   end

   // Handshake decodes straight from the state; results come from held registers
   always_comb begin
      bus.busy = (state_q == CALC) || (state_q == FIX);
      bus.done = (state_q == DONE);
      bus.hi   = hi_q;
      bus.lo   = lo_q;
      bus.Z    = z_q;
      bus.N    = n_q;
      bus.C    = c_q;
      bus.V    = v_q;
   end

endmodule
